mem_port_arbiter: RTL

Shares the single 13-bit-address / 8-bit-data memory port between two requesters: port 0 (instruction fetch) and port 1 (data load/store). A registered FSM arbitrates round-robin, holds the grant for a fixed-latency access and returns read data with a one-cycle done pulse. It also drives the select for the existing 13-bit address and 8-bit write-data steering muxes in front of memory.

---
 rtl/mem_port_arbiter_pkg.sv | 20 ++
 rtl/mem_port_arbiter_rr_pick2.sv | 12 +
 rtl/mux13.sv | 9 +
 rtl/mux8.sv | 9 +
 rtl/mem_port_arbiter.sv | 123 ++++++++++++
 5 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared widths, FSM state encoding and counter helpers for the two-port
// memory arbiter.
package mem_port_arbiter_pkg;

    localparam int unsigned ADDR_W = 13;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned CNT_W  = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ACCESS = 2'b01,
        ST_DONE   = 2'b10
    } arb_state_e;

    // Counter preload so that ACCESS spans exactly lat cycles (counts down to zero).
    function automatic logic [CNT_W-1:0] lat_to_cnt(input int unsigned lat);
        return CNT_W'(lat - 1);
    endfunction

endpackage

// File: rtl/mem_port_arbiter_rr_pick2.sv
// Combinational 2-way round-robin picker: on a tie the port that did not
// win last time is chosen.
module rr_pick2 (
    input  logic req0,
    input  logic req1,
    input  logic last,
    output logic valid,
    output logic winner
);
    assign valid  = req0 | req1;
    assign winner = (req0 & req1) ? ~last : req1;
endmodule

// File: rtl/mux13.sv
// Existing 13-bit 2:1 address steering mux in front of memory.
module mux13 (
    input  logic        sel,
    input  logic [12:0] a0,
    input  logic [12:0] a1,
    output logic [12:0] y
);
    assign y = sel ? a1 : a0;
endmodule

// File: rtl/mux8.sv
// Existing 8-bit 2:1 write-data steering mux in front of memory.
module mux8 (
    input  logic       sel,
    input  logic [7:0] a0,
    input  logic [7:0] a1,
    output logic [7:0] y
);
    assign y = sel ? a1 : a0;
endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one fixed-latency memory port between an
// instruction-fetch port (0) and a data load/store port (1).
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned MEM_LAT = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              done0,
    output logic              done1,
    output logic [DATA_W-1:0] rdata,
    output logic              busy,
    output logic              mux_sel,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_en,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [CNT_W-1:0] LAT_CNT = lat_to_cnt(MEM_LAT);

    arb_state_e        state_q, state_d;
    logic              mux_sel_q, mux_sel_d;
    logic              last_q, last_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;

    logic pick_valid;
    logic pick_winner;
    logic sel_we;

    rr_pick2 u_pick (
        .req0   (req0),
        .req1   (req1),
        .last   (last_q),
        .valid  (pick_valid),
        .winner (pick_winner)
    );

    assign sel_we = mux_sel_q ? we1 : we0;

    always_comb begin
        state_d   = state_q;
        mux_sel_d = mux_sel_q;
        last_d    = last_q;
        cnt_d     = cnt_q;
        rdata_d   = rdata_q;
        unique case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    mux_sel_d = pick_winner;
                    cnt_d     = LAT_CNT;
                    state_d   = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                if (cnt_q == '0) begin
                    if (!sel_we) begin
                        rdata_d = mem_rdata;
                    end
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_DONE: begin
                last_d  = mux_sel_q;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // last resets to 1 so port 0 wins the first tie.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            mux_sel_q <= 1'b0;
            last_q    <= 1'b1;
            cnt_q     <= '0;
            rdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            mux_sel_q <= mux_sel_d;
            last_q    <= last_d;
            cnt_q     <= cnt_d;
            rdata_q   <= rdata_d;
        end
    end

    mux13 u_addr_mux (
        .sel (mux_sel_q),
        .a0  (addr0),
        .a1  (addr1),
        .y   (mem_addr)
    );

    mux8 u_wdata_mux (
        .sel (mux_sel_q),
        .a0  (wdata0),
        .a1  (wdata1),
        .y   (mem_wdata)
    );

    assign mux_sel = mux_sel_q;
    assign rdata   = rdata_q;
    assign mem_en  = (state_q == ST_ACCESS);
    assign mem_we  = mem_en & sel_we;
    assign busy    = (state_q == ST_ACCESS) || (state_q == ST_DONE);
    assign done0   = (state_q == ST_DONE) & ~mux_sel_q;
    assign done1   = (state_q == ST_DONE) &  mux_sel_q;

endmodule
